// File: rtl/wb_seq_pkg.sv
// Shared opcode and FSM state encodings for the Wishbone command sequencer,
// for reuse by table generators and benches.
package wb_seq_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK = 3'd2;
  localparam logic [2:0] ST_RELEASE  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERROR    = 3'd5;

endpackage

// File: rtl/wb_seq_timeout.sv
// Loadable down-counter for the ack timeout; expire fires on the TIMEOUT-th
// enabled cycle after load, so the bus is held exactly TIMEOUT clocks.
module wb_seq_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (load)             cnt <= CW'(TIMEOUT);
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expire = en && (cnt <= CW'(1));

endmodule

// File: rtl/wb_cmd_sequencer.sv
// Table-driven Wishbone master replaying WRITE/READ/POLL/END entries from an
// external table. Optional ack timeout is built when WB_SEQ_TIMEOUT_EN is defined.
module wb_cmd_sequencer
  import wb_seq_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int POLL_MAX = 255,
  parameter int TIMEOUT  = 1023,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_idx,
  output logic [IDX_W-1:0]  cmd_idx,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_i,
  input  logic [DATA_W-1:0] wb_dat_o,
  input  logic              wb_ack
);

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] cap;
  logic [7:0]        poll_cnt;
  logic [7:0]        poll_nxt;
  logic              last, poll_ok, tmo;

  assign poll_nxt = poll_cnt + 8'd1;
  assign last     = (cmd_idx == IDX_W'(DEPTH - 1));
  assign poll_ok  = ((cap & cmd_mask) == (cmd_dat & cmd_mask));
  assign busy     = (state == ST_FETCH) || (state == ST_WAIT_ACK) || (state == ST_RELEASE);

`ifdef WB_SEQ_TIMEOUT_EN
  wb_seq_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock  (clock),
    .reset  (reset),
    .load   (state == ST_FETCH),
    .en     (state == ST_WAIT_ACK),
    .expire (tmo)
  );
`else
  // No ack timeout in this build: WAIT_ACK waits for the slave indefinitely.
  assign tmo = (TIMEOUT < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cmd_idx  <= '0;
      poll_cnt <= '0;
      op_q     <= OP_WRITE;
      cap      <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_idx  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_idx   <= '0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_dat_i <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cmd_idx  <= '0;
            poll_cnt <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          op_q <= cmd_op;
          if (cmd_op == OP_END) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wb_we    <= (cmd_op == OP_WRITE);
            wb_adr   <= cmd_adr;
            wb_dat_i <= (cmd_op == OP_WRITE) ? cmd_dat : '0;
            state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          // Ack wins over a timeout expiring in the same cycle.
          if (wb_ack || tmo) begin
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_adr   <= '0;
            wb_dat_i <= '0;
            if (wb_ack) begin
              cap   <= wb_dat_o;
              state <= ST_RELEASE;
              if (op_q == OP_READ) begin
                rd_valid <= 1'b1;
                rd_data  <= wb_dat_o;
                rd_idx   <= cmd_idx;
              end
            end else begin
              error   <= 1'b1;
              err_idx <= cmd_idx;
              state   <= ST_ERROR;
            end
          end
        end
        ST_RELEASE: begin
          if (!wb_ack) begin
            if (op_q != OP_POLL || poll_ok) begin
              poll_cnt <= '0;
              if (last) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                cmd_idx <= cmd_idx + 1'b1;
                state   <= ST_FETCH;
              end
            end else begin
              poll_cnt <= poll_nxt;
              if (poll_nxt == 8'(POLL_MAX)) begin
                error   <= 1'b1;
                err_idx <= cmd_idx;
                state   <= ST_ERROR;
              end else begin
                state <= ST_FETCH;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Self-checking bench for wb_cmd_sequencer: behavioural table + slave model,
// bus-access/read-back scoreboard, poll-compare vector table, corner sequences.
module tb_wb_cmd_sequencer;
  import wb_seq_pkg::*;

  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int PMAX  = 4;
  localparam int TMO   = 16;

  logic          clock = 1'b0;
  logic          reset, start;
  logic          busy, done, error, rd_valid;
  logic [IW-1:0] err_idx, cmd_idx, rd_idx;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_adr, cmd_dat, cmd_mask, rd_data;
  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [7:0]    wb_adr, wb_dat_i, wb_dat_o;

  always #5 clock = ~clock;

  wb_cmd_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .POLL_MAX(PMAX), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .err_idx(err_idx), .cmd_idx(cmd_idx), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_mask(cmd_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Command table, read combinationally by cmd_idx.
  logic [1:0] t_op   [DEPTH];
  logic [7:0] t_adr  [DEPTH];
  logic [7:0] t_dat  [DEPTH];
  logic [7:0] t_mask [DEPTH];
  assign cmd_op   = t_op[cmd_idx];
  assign cmd_adr  = t_adr[cmd_idx];
  assign cmd_dat  = t_dat[cmd_idx];
  assign cmd_mask = t_mask[cmd_idx];

  task automatic clr_tab();
    for (int i = 0; i < DEPTH; i++) begin
      t_op[i] = OP_END; t_adr[i] = 8'h00; t_dat[i] = 8'h00; t_mask[i] = 8'h00;
    end
  endtask

  task automatic ent(input int i, input logic [1:0] op, input logic [7:0] a, d, m);
    t_op[i] = op; t_adr[i] = a; t_dat[i] = d; t_mask[i] = m;
  endtask

  // Scoreboard queues.
  typedef struct { logic we; logic [7:0] adr; logic [7:0] dat; } acc_t;
  typedef struct { logic [7:0] d; logic [IW-1:0] i; } rd_t;
  acc_t exp_acc[$];
  rd_t  exp_rd[$];

  task automatic exp_a(input logic we, input logic [7:0] a, d);
    acc_t e;
    e.we = we; e.adr = a; e.dat = d;
    exp_acc.push_back(e);
  endtask

  task automatic exp_r(input logic [7:0] d, input logic [IW-1:0] i);
    rd_t e;
    e.d = d; e.i = i;
    exp_rd.push_back(e);
  endtask

  // Slave model: ack after ack_lat waiting cycles, hold ack for ack_hold clocks.
  int         ack_lat  = 0;
  int         ack_hold = 1;
  bit         no_ack   = 1'b0;
  logic [7:0] rd_dflt  = 8'h00;
  logic [7:0] rdq[$];
  int         wt, left;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_ack <= 1'b0; wb_dat_o <= 8'h00; wt <= 0; left <= 0;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 1) wb_ack <= 1'b0;
    end else if (wb_cyc && wb_stb && !no_ack) begin
      if (wt >= ack_lat) begin
        wb_ack <= 1'b1;
        left   <= ack_hold;
        wt     <= 0;
        if (!wb_we && rdq.size() > 0) wb_dat_o <= rdq.pop_front();
        else                          wb_dat_o <= wb_we ? 8'h00 : rd_dflt;
      end else begin
        wt <= wt + 1;
      end
    end else begin
      wt <= 0;
    end
  end

  // Monitor: pops the scoreboard on every new bus access and every rd_valid.
  logic cyc_prev = 1'b0;
  bit   seen     = 1'b0;
  int   gap = 0, last_gap = 0, n_acc = 0, n_rd = 0;

  initial forever begin
    @(negedge clock);
    if (wb_cyc && !cyc_prev) begin
      acc_t e;
      n_acc++;
      if (seen) chk("cyc_gap_min2", gap >= 2, 1);
      last_gap = gap;
      gap      = 0;
      seen     = 1'b1;
      chk("acc_expected", exp_acc.size() > 0, 1);
      if (exp_acc.size() > 0) begin
        e = exp_acc.pop_front();
        chk("bus_access", {wb_stb, wb_we, wb_adr, wb_dat_i}, {1'b1, e.we, e.adr, e.dat});
      end
    end else if (!wb_cyc && seen) begin
      gap++;
    end
    cyc_prev = wb_cyc;
    if (rd_valid) begin
      rd_t r;
      n_rd++;
      chk("rd_valid_cyc_low", wb_cyc, 0);
      chk("rd_expected", exp_rd.size() > 0, 1);
      if (exp_rd.size() > 0) begin
        r = exp_rd.pop_front();
        chk("rd_data_idx", {rd_data, rd_idx}, {r.d, r.i});
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while (!((done || error) && !busy) && n < bound) begin
      @(negedge clock); n++;
    end
    chk("end_in_budget", n < bound, 1);
    chk("acc_left", exp_acc.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
  endtask

  function automatic logic [63:0] outs();
    return {busy, done, error, err_idx, cmd_idx, rd_valid, rd_data, rd_idx,
            wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i};
  endfunction

  // Poll-compare vectors: {mask, expected, slave data, passes}.
  typedef struct { logic [7:0] mask; logic [7:0] expv; logic [7:0] rdv; bit ok; } pv_t;
  pv_t pv[6];

  initial begin
    pv[0] = '{8'hFF, 8'h3C, 8'h3C, 1'b1};
    pv[1] = '{8'hF0, 8'h3C, 8'h35, 1'b1};
    pv[2] = '{8'h0F, 8'h3C, 8'h35, 1'b0};
    pv[3] = '{8'h00, 8'hFF, 8'h00, 1'b1};
    pv[4] = '{8'h80, 8'h80, 8'h7F, 1'b0};
    pv[5] = '{8'h01, 8'h01, 8'hFF, 1'b1};

    reset = 1'b1; start = 1'b0; clr_tab();
    repeat (3) @(negedge clock);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clock);

    // WRITE then READ then END; start->cyc latency is 2 clocks.
    clr_tab();
    ent(0, OP_WRITE, 8'h59, 8'h91, 8'h00);
    ent(1, OP_READ,  8'h5B, 8'h00, 8'h00);
    exp_a(1'b1, 8'h59, 8'h91); exp_a(1'b0, 8'h5B, 8'h00); exp_r(8'hA5, 4'd1);
    rdq.push_back(8'hA5); n_rd = 0;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1 chk("start_lat_clk1", wb_cyc, 0); start = 1'b0;
    @(posedge clock); #1 chk("start_lat_clk2", wb_cyc, 1);
    wait_end(100);
    chk("wr_rd_done_err", {done, error}, 2'b10);
    chk("wr_rd_rdvalid_cnt", n_rd, 1);
    chk("min_cyc_gap", last_gap, 2);

    // POLL: three misses then a hit.
    clr_tab();
    ent(0, OP_POLL, 8'h5A, 8'h10, 8'h10);
    rdq.push_back(8'h00); rdq.push_back(8'h00); rdq.push_back(8'h00); rdq.push_back(8'h10);
    for (int k = 0; k < 4; k++) exp_a(1'b0, 8'h5A, 8'h00);
    n_acc = 0; n_rd = 0;
    pulse_start(); wait_end(200);
    chk("poll_hit_done_err", {done, error}, 2'b10);
    chk("poll_hit_reads", n_acc, 4);
    chk("poll_no_rdvalid", n_rd, 0);

    // POLL exhausted at entry 2.
    clr_tab();
    ent(0, OP_WRITE, 8'h40, 8'h01, 8'h00);
    ent(1, OP_WRITE, 8'h41, 8'h02, 8'h00);
    ent(2, OP_POLL,  8'h42, 8'h01, 8'h01);
    rd_dflt = 8'h00;
    exp_a(1'b1, 8'h40, 8'h01); exp_a(1'b1, 8'h41, 8'h02);
    for (int k = 0; k < PMAX; k++) exp_a(1'b0, 8'h42, 8'h00);
    n_acc = 0;
    pulse_start(); wait_end(300);
    chk("poll_fail_done_err", {done, error}, 2'b01);
    chk("poll_fail_err_idx", err_idx, 2);
    chk("poll_fail_accesses", n_acc, 2 + PMAX);

    // Poll-compare vector table.
    for (int v = 0; v < 6; v++) begin
      clr_tab();
      ent(0, OP_POLL, 8'h70, pv[v].expv, pv[v].mask);
      rd_dflt = pv[v].rdv;
      for (int k = 0; k < (pv[v].ok ? 1 : PMAX); k++) exp_a(1'b0, 8'h70, 8'h00);
      n_acc = 0;
      pulse_start(); wait_end(200);
      chk($sformatf("pv%0d_done_err", v), {done, error}, pv[v].ok ? 2'b10 : 2'b01);
      chk($sformatf("pv%0d_reads", v), n_acc, pv[v].ok ? 1 : PMAX);
    end

    // Slave holds ack 3 clocks: next cyc only after ack has dropped.
    ack_hold = 3;
    clr_tab();
    ent(0, OP_WRITE, 8'h10, 8'h01, 8'h00);
    ent(1, OP_WRITE, 8'h11, 8'h02, 8'h00);
    exp_a(1'b1, 8'h10, 8'h01); exp_a(1'b1, 8'h11, 8'h02);
    pulse_start(); wait_end(100);
    chk("ack_hold_gap", last_gap, 4);
    chk("ack_hold_done", done, 1);
    ack_hold = 1;

    // Async reset mid WAIT_ACK, no retry afterwards.
    no_ack = 1'b1;
    clr_tab();
    ent(0, OP_WRITE, 8'h20, 8'h33, 8'h00);
    exp_a(1'b1, 8'h20, 8'h33);
    pulse_start();
    begin
      int n = 0;
      while (!wb_cyc && n < 20) begin @(negedge clock); n++; end
      chk("rst_cyc_seen", wb_cyc, 1);
    end
    @(negedge clock); reset = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    @(negedge clock); reset = 1'b0; no_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("no_retry_after_reset", {busy, wb_cyc, done, error}, 0);

    // Restart from entry 0; a start pulse mid-sequence is ignored.
    ack_lat = 3;
    clr_tab();
    ent(0, OP_WRITE, 8'h20, 8'h33, 8'h00);
    ent(1, OP_WRITE, 8'h21, 8'h44, 8'h00);
    exp_a(1'b1, 8'h20, 8'h33); exp_a(1'b1, 8'h21, 8'h44);
    n_acc = 0;
    pulse_start();
    begin
      int n = 0;
      while (!(wb_cyc && cmd_idx == 1) && n < 50) begin @(negedge clock); n++; end
      chk("busy_second_entry", {wb_cyc, cmd_idx}, {1'b1, 4'd1});
    end
    pulse_start();
    wait_end(100);
    chk("busy_start_ignored_acc", n_acc, 2);
    chk("busy_start_done", {done, error}, 2'b10);
    ack_lat = 0;

    // No END: sequence stops after entry DEPTH-1.
    clr_tab();
    for (int i = 0; i < DEPTH; i++) begin
      ent(i, OP_WRITE, 8'(i), ~8'(i), 8'h00);
      exp_a(1'b1, 8'(i), ~8'(i));
    end
    n_acc = 0;
    pulse_start(); wait_end(400);
    chk("depth_done_err", {done, error}, 2'b10);
    chk("depth_cmd_idx", cmd_idx, DEPTH - 1);
    chk("depth_accesses", n_acc, DEPTH);

    // Slave never acks.
    no_ack = 1'b1;
    clr_tab();
    ent(0, OP_READ, 8'h30, 8'h00, 8'h00);
    exp_a(1'b0, 8'h30, 8'h00);
    n_rd = 0;
    pulse_start();
    @(negedge clock);
    begin
      int hi = 0;
      while (wb_cyc && hi < 60) begin @(negedge clock); hi++; end
`ifdef WB_SEQ_TIMEOUT_EN
      chk("tmo_cyc_len", hi, TMO);
      chk("tmo_done_err", {done, error}, 2'b01);
      chk("tmo_err_idx", err_idx, 0);
      chk("tmo_no_rdvalid", n_rd, 0);
      chk("tmo_bus_idle", {busy, wb_cyc, wb_stb}, 0);
`else
      chk("no_tmo_cyc_held", hi, 60);
      chk("no_tmo_busy", {busy, wb_cyc, error}, 3'b110);
`endif
    end
    chk("noack_acc_left", exp_acc.size(), 0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; no_ack = 1'b0;
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/wb_cmd_sequencer.md
# wb_cmd_sequencer

Table-driven Wishbone master that replays a programmable list of register accesses (write, read, poll-until-match) into a slave such as the EFB SPI core. It generalises the fixed two-access SPI bring-up controller with configurable widths, depth, read-back reporting, bounded polling and optional ack timeout. It sits between board-level init/control logic and the Wishbone slave bus.

## Interface
- ADDR_W, 8, Wishbone address width
- DATA_W, 8, Wishbone data width
- DEPTH, 16, command table entries; index width IDX_W = clog2(DEPTH)
- POLL_MAX, 255, poll attempts before error, 1..255
- TIMEOUT, 1023, clocks to wait for wb_ack (used only with WB_SEQ_TIMEOUT_EN)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  launch sequence from entry 0; ignored while busy
- busy  out  1  sequence in progress
- done  out  1  level; END reached without error
- error  out  1  level; poll exhausted or ack timeout
- err_idx  out  IDX_W  entry that failed
- cmd_idx  out  IDX_W  table address to external ROM/regfile
- cmd_op  in  2  00 WRITE, 01 READ, 10 POLL, 11 END (combinational from cmd_idx)
- cmd_adr  in  ADDR_W  target address
- cmd_dat  in  DATA_W  write data, or POLL expected value
- cmd_mask  in  DATA_W  POLL compare mask
- rd_valid  out  1  one-cycle pulse, READ data captured
- rd_data  out  DATA_W  captured read data
- rd_idx  out  IDX_W  entry that produced rd_data
- wb_cyc, wb_stb, wb_we  out  1  Wishbone master controls
- wb_adr  out  ADDR_W  address
- wb_dat_i  out  DATA_W  data to slave
- wb_dat_o  in  DATA_W  data from slave
- wb_ack  in  1  slave acknowledge

## Operation
- Reset: every output 0, cmd_idx 0, poll counter 0, state IDLE.
- States: IDLE, FETCH, WAIT_ACK, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear done/error, cmd_idx<=0, poll cnt<=0, -> FETCH.
- FETCH: END -> DONE (done=1). Otherwise register wb_cyc=wb_stb=1, wb_we=(op==WRITE), wb_adr=cmd_adr, wb_dat_i=(WRITE ? cmd_dat : 0) -> WAIT_ACK.
- WAIT_ACK: hold all bus outputs; on wb_ack drop cyc/stb/we, zero adr/dat_i, capture wb_dat_o -> RELEASE. READ: rd_data/rd_idx loaded, rd_valid pulses with the bus drop.
- RELEASE: stay until wb_ack low. Then:
  - WRITE/READ, or POLL with (captured & cmd_mask)==(cmd_dat & cmd_mask): poll cnt<=0; cmd_idx==DEPTH-1 -> DONE, else cmd_idx+1 -> FETCH.
  - POLL mismatch: cnt+1; cnt+1==POLL_MAX -> ERROR (err_idx=cmd_idx), else FETCH same entry.
- busy=1 in FETCH/WAIT_ACK/RELEASE. done/error are exclusive levels held until next start.
- start while busy: ignored, no effect on sequence.
- Async reset mid-transfer: bus released at once, outputs to reset values; no retry on exit.

## Timing
- start -> wb_cyc high: 2 clocks (IDLE->FETCH->bus registered).
- Minimum access: FETCH, WAIT_ACK (1 clk if ack immediate), RELEASE (1 clk) = 3 clocks per entry; back-to-back cyc gap >= 2 clocks.
- rd_valid asserted exactly the cycle wb_cyc first reads 0 after the ack.
- All outputs registered; cmd_* sampled only in FETCH and RELEASE (table must be stable for the current cmd_idx).

## Configuration
- WB_SEQ_TIMEOUT_EN defined: counter clears on FETCH, counts in WAIT_ACK; reaching TIMEOUT drops bus (as on ack), -> ERROR, err_idx=cmd_idx, no rd_valid.
- Undefined: WAIT_ACK waits indefinitely; TIMEOUT ignored; no counter logic.

## Structure
- Shared package wb_seq_pkg: opcode constants (OP_WRITE, OP_READ, OP_POLL, OP_END) and state encodings, for reuse by table generators and benches.
- One sub-module, wb_seq_timeout: loadable down-counter with expire flag, instantiated only under WB_SEQ_TIMEOUT_EN.
- Table storage external; not part of this block.

## Test plan
- Table {WRITE 0x59<-0x91, READ 0x5B, END}, slave acks next cycle, returns 0xA5 -> write seen with we=1, read with we=0, rd_valid once with rd_data=0xA5, rd_idx=1, done=1.
- POLL adr 0x5A mask 0x10 exp 0x10; slave returns 0x00 three times, then 0x10 -> four bus reads, then advance, done=1, error=0.
- POLL_MAX=4, slave always 0x00 -> exactly 4 reads, error=1, err_idx=0, done=0.
- Slave holds wb_ack high 3 clocks -> sequencer stays in RELEASE, next cyc only after ack low.
- Assert reset mid WAIT_ACK, then start -> all outputs 0 during reset; sequence restarts at entry 0. start pulsed while busy -> no effect.
- WB_SEQ_TIMEOUT_EN, TIMEOUT=16, slave never acks -> cyc drops after 16 clocks, error=1, err_idx=current entry; undefined build -> cyc held indefinitely.
